// File: rtl/ibex_rf_march_bist_ctrl.sv
// rtl/ibex_rf_march_bist_ctrl.sv - March C- BIST sequencer for the core register file
module ibex_rf_march_bist_ctrl #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 5,
  parameter int unsigned       FIRST_ADDR   = 1,
  parameter int unsigned       LAST_ADDR    = 31,
  parameter logic [DATA_W-1:0] BG_PATTERN   = '0,
  parameter int unsigned       IDLE_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              halt_req_o,
  input  logic              core_idle_i,
  output logic              rf_sel_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [2:0]        fail_elem_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o
);

  localparam int unsigned TIMER_W = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(IDLE_TIMEOUT);
  localparam logic [ADDR_W-1:0]  FIRST_A   = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0]  LAST_A    = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_MARCH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;

  // Element decode: M0 is write-only, M5 read-only, M3/M4 walk downwards.
  logic              has_read, has_write, down, next_down, at_end;
  logic              read_cyc, write_cyc;
  logic [DATA_W-1:0] rd_exp, wr_data;

  assign has_read  = (elem_q != 3'd0);
  assign has_write = (elem_q != 3'd5);
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign next_down = (elem_q == 3'd2) || (elem_q == 3'd3);
  assign at_end    = down ? (addr_q == FIRST_A) : (addr_q == LAST_A);
  assign read_cyc  = has_read && !phase_q;
  assign write_cyc = has_write && (phase_q || !has_read);
  assign rd_exp    = elem_q[0] ? BG_PATTERN : ~BG_PATTERN;
  assign wr_data   = elem_q[0] ? ~BG_PATTERN : BG_PATTERN;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      elem_q      <= '0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_WAIT;
          timer_d     = '0;
          fail_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      S_WAIT: begin
        // Idle arriving on the last allowed cycle still wins over the timeout.
        if (core_idle_i) begin
          state_d = S_MARCH;
          elem_d  = 3'd0;
          addr_d  = FIRST_A;
          phase_d = 1'b0;
        end else if (timer_q == TIMEOUT_T) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_MARCH: begin
        if (read_cyc && (rf_rdata_i != rd_exp)) begin
          state_d     = S_DONE;
          fail_d      = 1'b1;
          fail_elem_d = elem_q;
          fail_addr_d = addr_q;
          fail_data_d = rf_rdata_i;
        end else if (read_cyc && has_write) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (at_end) begin
            if (elem_q == 3'd5) begin
              state_d = S_DONE;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = next_down ? LAST_A : FIRST_A;
            end
          end else if (down) begin
            addr_d = addr_q - 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign halt_req_o  = (state_q == S_WAIT) || (state_q == S_MARCH);
  assign rf_sel_o    = (state_q == S_MARCH);
  assign rf_we_o     = rf_sel_o && write_cyc;
  assign rf_waddr_o  = rf_sel_o ? addr_q : '0;
  assign rf_raddr_o  = rf_sel_o ? addr_q : '0;
  assign rf_wdata_o  = rf_we_o ? wr_data : '0;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_ibex_rf_march_bist_ctrl.sv
// tb/tb_ibex_rf_march_bist_ctrl.sv - randomized bench for the RF March C- BIST controller
module tb_ibex_rf_march_bist_ctrl;

  localparam int          N     = 31;
  localparam int          FIRST = 1;
  localparam int          LAST  = 31;
  localparam logic [31:0] BG    = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        core_idle_i = 1'b0;
  logic        halt_req_o, rf_sel_o, rf_we_o, busy_o, done_o, fail_o, timeout_o;
  logic [4:0]  rf_waddr_o, rf_raddr_o, fail_addr_o;
  logic [31:0] rf_wdata_o, rf_rdata_i, fail_data_o;
  logic [2:0]  fail_elem_o;

  int total = 0;
  int bad = 0;

  ibex_rf_march_bist_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .halt_req_o  (halt_req_o),
    .core_idle_i (core_idle_i),
    .rf_sel_o    (rf_sel_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_we_o     (rf_we_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .fail_elem_o (fail_elem_o),
    .fail_addr_o (fail_addr_o),
    .fail_data_o (fail_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file model with optional stuck-at bit and decoder-alias faults.
  logic [31:0] mem [0:31];
  bit          sa_en = 0;
  int          sa_addr = 0;
  int          sa_bit = 0;
  logic        sa_val = 1'b0;
  bit          cp_en = 0;
  int          cp_a = 0;
  int          cp_b = 0;

  always_comb begin
    rf_rdata_i = mem[rf_raddr_o];
    if (sa_en && int'(rf_raddr_o) == sa_addr) rf_rdata_i[sa_bit] = sa_val;
  end

  always @(posedge clk_i) begin
    if (rf_sel_o && rf_we_o) begin
      mem[rf_waddr_o] = rf_wdata_o;
      if (cp_en && int'(rf_waddr_o) == cp_a) mem[cp_b] = rf_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: expected op sequence and outcome from the March C- element table.
  logic [42:0] exp_q [$];
  bit          r_fail;
  int          r_elem, r_addr, r_writes;
  logic [31:0] r_data;

  task automatic build_ref();
    logic [31:0] m [0:31];
    logic [31:0] obs, e_rd, e_wr;
    int a;
    for (int i = 0; i < 32; i++) m[i] = mem[i];
    exp_q.delete();
    r_fail = 0; r_elem = 0; r_addr = 0; r_data = '0; r_writes = 0;
    for (int e = 0; e < 6; e++) begin
      e_rd = (e % 2 == 1) ? BG : ~BG;
      e_wr = (e % 2 == 1) ? ~BG : BG;
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? LAST - i : FIRST + i;
        if (e != 0) begin
          exp_q.push_back({1'b0, 5'(a), 5'(a), 32'h0});
          obs = m[a];
          if (sa_en && a == sa_addr) obs[sa_bit] = sa_val;
          if (obs != e_rd) begin
            r_fail = 1; r_elem = e; r_addr = a; r_data = obs;
            return;
          end
        end
        if (e != 5) begin
          exp_q.push_back({1'b1, 5'(a), 5'(a), e_wr});
          r_writes++;
          m[a] = e_wr;
          if (cp_en && a == cp_a) m[cp_b] = e_wr;
        end
      end
    end
  endtask

  task automatic run_test(input int idle_dly, input bit poke, input int rst_at);
    int  wait_cyc = 0;
    int  march_cyc = 0;
    int  wr_cnt = 0;
    int  idx = 0;
    bit  fin = 0;
    bit  rst_hit = 0;
    bit  to_exp;
    for (int a = 0; a < 32; a++) mem[a] = $urandom;
    build_ref();
    to_exp = (idle_dly > 256);
    @(negedge clk_i);
    start_i = 1'b1;
    core_idle_i = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        check("done_sel", rf_sel_o, 0);
        check("done_halt", halt_req_o, 0);
        check("done_busy", busy_o, 1);
        fin = 1;
      end else if (rf_sel_o) begin
        march_cyc++;
        check("march_halt", halt_req_o, 1);
        if (idx < exp_q.size())
          check($sformatf("op%0d", idx),
                {rf_we_o, rf_waddr_o, rf_raddr_o, rf_we_o ? rf_wdata_o : 32'h0}, exp_q[idx]);
        idx++;
        if (rf_we_o) wr_cnt++;
        core_idle_i = 1'($urandom_range(0, 1));
        if (poke && march_cyc == 20) start_i = 1'b1;
        if (march_cyc == rst_at) begin
          rst_i = 1'b1;
          #1;
          check("rst_async", {rf_sel_o, halt_req_o, busy_o, done_o, rf_we_o}, 0);
          @(negedge clk_i);
          check("rst_hold", {rf_sel_o, halt_req_o, busy_o, done_o}, 0);
          rst_i = 1'b0;
          rst_hit = 1;
          fin = 1;
        end
      end else if (busy_o) begin
        wait_cyc++;
        core_idle_i = (wait_cyc >= idle_dly);
      end
    end
    if (rst_hit) return;
    check("done_seen", fin, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("post_idle", {busy_o, done_o, rf_sel_o}, 0);
    end
    check("wait_cycles", wait_cyc, to_exp ? 256 : idle_dly);
    check("march_cycles", march_cyc, to_exp ? 0 : exp_q.size());
    check("writes", wr_cnt, to_exp ? 0 : r_writes);
    check("timeout", timeout_o, to_exp);
    check("fail", fail_o, to_exp ? 0 : r_fail);
    if (!to_exp && r_fail) begin
      check("fail_elem", fail_elem_o, r_elem);
      check("fail_addr", fail_addr_o, r_addr);
      check("fail_data", fail_data_o, r_data);
    end
  endtask

  task automatic clear_faults();
    sa_en = 0;
    cp_en = 0;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem[a] = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_outs", {halt_req_o, rf_sel_o, rf_we_o, busy_o, done_o, fail_o, timeout_o,
                         fail_elem_o, fail_addr_o, fail_data_o, rf_waddr_o, rf_wdata_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_outs", {halt_req_o, rf_sel_o, busy_o, done_o}, 0);

    clear_faults();
    run_test(3, 0, -1);
    check("t1_writes", r_writes, 155);
    check("t1_fail", fail_o, 0);

    sa_en = 1; sa_addr = 5; sa_bit = 3; sa_val = 1'b1;
    run_test(2, 0, -1);
    check("t2_elem", fail_elem_o, 1);
    check("t2_addr", fail_addr_o, 5);
    check("t2_data", fail_data_o, 32'h8);

    clear_faults();
    cp_en = 1; cp_a = 9; cp_b = 7;
    run_test(5, 0, -1);
    check("t3_elem", fail_elem_o, 3);
    check("t3_addr", fail_addr_o, 7);
    check("t3_data", fail_data_o, 32'hFFFF_FFFF);

    clear_faults();
    run_test(1000000, 0, -1);
    check("t4_timeout", timeout_o, 1);

    run_test(4, 1, -1);
    check("t5_fail", {fail_o, timeout_o}, 0);

    run_test(3, 0, 120);
    run_test(3, 0, -1);
    check("t6_fresh", {fail_o, timeout_o}, 0);

    run_test(256, 0, -1);

    for (int r = 0; r < 8; r++) begin
      clear_faults();
      case ($urandom_range(0, 2))
        1: begin
          sa_en = 1; sa_addr = $urandom_range(FIRST, LAST);
          sa_bit = $urandom_range(0, 31); sa_val = 1'($urandom_range(0, 1));
        end
        2: begin
          cp_en = 1; cp_a = $urandom_range(FIRST, LAST);
          cp_b = $urandom_range(FIRST, LAST - 1);
          if (cp_b >= cp_a) cp_b++;
        end
        default: ;
      endcase
      run_test($urandom_range(1, 20), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
